// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding,
// step/counter sizing helpers and a parameter legality check.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit steps needed to cover a full operand.
    function automatic int calc_steps(input int width, input int digit);
        if (digit > 0) begin
            return width / digit;
        end else begin
            return 1;
        end
    endfunction

    // Counter must be able to hold 0..STEPS.
    function automatic int cnt_width(input int width, input int digit);
        int steps;
        steps = calc_steps(width, digit);
        if (steps < 1) begin
            return 1;
        end else begin
            return $clog2(steps + 1);
        end
    endfunction

    // WIDTH >= 1, DIGIT >= 1 and DIGIT divides WIDTH.
    function automatic bit params_legal(input int width, input int digit);
        return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_addsub_add_digit.sv
// Combinational DIGIT-bit ripple of full adders. Also exposes the carry into
// the top bit so the caller can form signed overflow on the final digit.
module add_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [DIGIT:0] w_c;

    // Ripple the carry through DIGIT full adders.
    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
        end
        co    = w_c[DIGIT];
        c_top = w_c[DIGIT-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Operands are latched on start, processed
// DIGIT bits per clock LSB first, and sum/cout/ovf are published together
// with a one-cycle done pulse. Outputs hold between operations.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CW    = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    if (!params_legal(WIDTH, DIGIT)) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic             r_busy;
    logic             r_done;
    logic             w_busy_next;
    logic             w_done_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_ctop;
    logic [WIDTH-1:0] w_s_ext;
    logic [WIDTH-1:0] w_res_next;

    // A new operation is taken whenever the engine is not mid-run.
    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == LAST_STEP);

    add_digit #(.DIGIT(DIGIT)) u_add_digit (
        .x     (r_a[DIGIT-1:0]),
        .y     (r_b[DIGIT-1:0]),
        .ci    (r_carry),
        .s     (w_s),
        .co    (w_co),
        .c_top (w_ctop)
    );

    // Insert the fresh digit at the top of the result shift register.
    always_comb begin
        w_s_ext            = '0;
        w_s_ext[DIGIT-1:0] = w_s;
        w_res_next         = (r_res >> DIGIT) | (w_s_ext << (WIDTH - DIGIT));
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = start ? RUN : IDLE;
            RUN:     w_state_next = w_last ? DONE : RUN;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake outputs for the upcoming state.
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_state_next)
            RUN:     w_busy_next = 1'b1;
            DONE:    w_done_next = 1'b1;
            default: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
        endcase
    end

    // Operand capture, digit-serial datapath and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~borrow, hence the inversions.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CW'(1);
            r_res   <= w_res_next;
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_co;
                r_ovf  <= w_ctop ^ w_co;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (8/1, 16/4, 3/1) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_serial_addsub;

    logic        clk;
    logic [2:0]  rst_v   = 3'b111;
    logic [2:0]  start_v = 3'b000;
    logic [2:0]  sub_v   = 3'b000;
    logic [2:0]  cin_v   = 3'b000;
    logic [31:0] op_a [3];
    logic [31:0] op_b [3];

    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [2:0]  cout_v;
    wire  [2:0]  ovf_v;
    wire  [7:0]  sum0;
    wire  [15:0] sum1;
    wire  [2:0]  sum2;

    int n_tests = 0;
    int n_fail  = 0;
    int ndone2  = 0;

    // Model state: remaining busy cycles, pending and visible results.
    int          m_cnt  [3];
    logic        m_done [3];
    logic [33:0] p_res  [3];
    logic [33:0] m_res  [3];

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .sub(sub_v[0]),
        .a(op_a[0][7:0]), .b(op_b[0][7:0]), .cin(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]));

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .sub(sub_v[1]),
        .a(op_a[1][15:0]), .b(op_b[1][15:0]), .cin(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]));

    serial_addsub #(.WIDTH(3), .DIGIT(1)) u_dut3 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .sub(sub_v[2]),
        .a(op_a[2][2:0]), .b(op_b[2][2:0]), .cin(cin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int steps_of(int d);
        case (d)
            0:       return 8;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int wid_of(int d);
        case (d)
            0:       return 8;
            1:       return 16;
            default: return 3;
        endcase
    endfunction

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_calc(int w, logic s, logic c, logic [31:0] a, logic [31:0] b);
        longint md, ua, ub, r, sa, sb, sr, ci;
        logic   co, ov;
        md = longint'(1) << w;
        ua = longint'(a) & (md - 1);
        ub = longint'(b) & (md - 1);
        ci = longint'(c);
        if (!s) begin
            r  = ua + ub + ci;
            co = (r >= md);
        end else begin
            r  = ua - ub - ci;
            co = (r >= 0);
        end
        sa = (ua >= md / 2) ? ua - md : ua;
        sb = (ub >= md / 2) ? ub - md : ub;
        sr = s ? (sa - sb - ci) : (sa + sb + ci);
        ov = (sr < -(md / 2)) || (sr > (md / 2) - 1);
        return {ov, co, 32'(r & (md - 1))};
    endfunction

    function automatic logic [33:0] dut_res(int d);
        case (d)
            0:       return {ovf_v[0], cout_v[0], 24'd0, sum0};
            1:       return {ovf_v[1], cout_v[1], 16'd0, sum1};
            default: return {ovf_v[2], cout_v[2], 29'd0, sum2};
        endcase
    endfunction

    task automatic chk(string nm, int d, logic [33:0] got, logic [33:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, d, $time, got, exp);
        end
    endtask

    // Transaction-level model: an accepted op publishes STEPS+1 cycles later.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_v[d]) begin
                m_cnt[d]  <= 0;
                m_done[d] <= 1'b0;
                m_res[d]  <= '0;
                p_res[d]  <= '0;
            end else begin
                m_done[d] <= 1'b0;
                if (m_cnt[d] > 0) begin
                    m_cnt[d] <= m_cnt[d] - 1;
                    if (m_cnt[d] == 1) begin
                        m_done[d] <= 1'b1;
                        m_res[d]  <= p_res[d];
                    end
                end else if (start_v[d]) begin
                    m_cnt[d] <= steps_of(d);
                    p_res[d] <= ref_calc(wid_of(d), sub_v[d], cin_v[d], op_a[d], op_b[d]);
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("busy", d, 34'(busy_v[d]), 34'(m_cnt[d] > 0));
            chk("done", d, 34'(done_v[d]), 34'(m_done[d]));
            chk("result", d, dut_res(d), m_res[d]);
        end
    end

    // Count done pulses on the exhaustive instance.
    always @(negedge clk) begin
        if (done_v[2] === 1'b1) ndone2++;
    end

    task automatic op(int d, logic s, logic c, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        op_a[d] = a; op_b[d] = b; sub_v[d] = s; cin_v[d] = c; start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        op_a[d] = $urandom; op_b[d] = $urandom; sub_v[d] = ~s; cin_v[d] = ~c;
    endtask

    task automatic wait_done(int d, int bound, output int n);
        n = 0;
        while (done_v[d] !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (done_v[d] !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout dut%0d @%0t: no done within %0d cycles", d, $time, bound);
        end
    endtask

    task automatic chk_res(string nm, int d, logic [31:0] s, logic co, logic ov);
        chk(nm, d, dut_res(d), {ov, co, s});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        logic [7:0] v;
        for (int d = 0; d < 3; d++) begin
            op_a[d] = '0;
            op_b[d] = '0;
        end

        // Pin the reference model with hand-computed values.
        chk("model_add5A33", 0, ref_calc(8, 1'b0, 1'b0, 32'h5A, 32'h33), {1'b1, 1'b0, 32'h8D});
        chk("model_sub1020", 0, ref_calc(8, 1'b1, 1'b0, 32'h10, 32'h20), {1'b0, 1'b0, 32'hF0});
        chk("model_addFF01", 0, ref_calc(8, 1'b0, 1'b0, 32'hFF, 32'h01), {1'b0, 1'b1, 32'h00});
        chk("model_7Fcin",   0, ref_calc(8, 1'b0, 1'b1, 32'h7F, 32'h00), {1'b1, 1'b0, 32'h80});
        chk("model_w3_sub",  2, ref_calc(3, 1'b1, 1'b1, 32'h0, 32'h0),   {1'b0, 1'b0, 32'h7});
        chk("model_w3_add",  2, ref_calc(3, 1'b0, 1'b0, 32'h3, 32'h1),   {1'b1, 1'b0, 32'h4});

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_busy_done", d, {32'd0, busy_v[d], done_v[d]}, 34'd0);
            chk_res("reset_outputs", d, 32'h0, 1'b0, 1'b0);
        end
        rst_v = 3'b000;

        // Basic add with latency check.
        op(0, 1'b0, 1'b0, 32'h5A, 32'h33);
        wait_done(0, 20, n);
        chk("latency8", 0, 34'(n), 34'd8);
        chk_res("add_5A_33", 0, 32'h8D, 1'b0, 1'b1);

        op(0, 1'b1, 1'b0, 32'h10, 32'h20);
        wait_done(0, 20, n);
        chk_res("sub_10_20", 0, 32'hF0, 1'b0, 1'b0);

        op(0, 1'b0, 1'b0, 32'hFF, 32'h01);
        wait_done(0, 20, n);
        chk_res("add_FF_01", 0, 32'h00, 1'b1, 1'b0);

        // Start held through the run, second op taken in the DONE cycle.
        @(negedge clk);
        op_a[0] = 32'h5A; op_b[0] = 32'h33; sub_v[0] = 1'b0; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        op_a[0] = 32'h10; op_b[0] = 32'h20; sub_v[0] = 1'b1; cin_v[0] = 1'b0;
        wait_done(0, 20, n);
        chk("held_start_latency", 0, 34'(n), 34'd8);
        chk_res("held_start_result", 0, 32'h8D, 1'b0, 1'b1);
        @(negedge clk);
        start_v[0] = 1'b0; op_a[0] = $urandom; op_b[0] = $urandom; sub_v[0] = 1'b0;
        wait_done(0, 20, n);
        chk("b2b_latency", 0, 34'(n + 1), 34'd9);
        chk_res("b2b_result", 0, 32'hF0, 1'b0, 1'b0);

        // Reset on the fourth busy cycle aborts the operation.
        op(0, 1'b0, 1'b1, 32'h7F, 32'h00);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("abort_busy", 0, 34'(busy_v[0]), 34'd0);
        chk_res("abort_outputs", 0, 32'h0, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) pulses++;
        end
        chk("abort_no_done", 0, 34'(pulses), 34'd0);
        op(0, 1'b0, 1'b1, 32'h7F, 32'h00);
        wait_done(0, 20, n);
        chk_res("after_abort_7F", 0, 32'h80, 1'b0, 1'b1);

        // 16-bit operand, 4 bits per clock.
        op(1, 1'b0, 1'b0, 32'hFFFF, 32'h0001);
        wait_done(1, 20, n);
        chk("latency16x4", 1, 34'(n + 1), 34'd5);
        chk_res("add_FFFF_0001", 1, 32'h0000, 1'b1, 1'b0);
        op(1, 1'b1, 1'b0, 32'h8000, 32'h0001);
        wait_done(1, 20, n);
        chk_res("sub_8000_0001", 1, 32'h7FFF, 1'b1, 1'b1);

        // Every {sub, cin, a, b} combination on the 3-bit instance.
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            op(2, v[7], v[6], {29'd0, v[5:3]}, {29'd0, v[2:0]});
            wait_done(2, 10, n);
        end
        @(negedge clk);
        chk("w3_done_count", 2, 34'(ndone2), 34'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
